// File: rtl/trena_pkg.sv
// Shared trena definitions: rx FSM state codes, 7E1 frame constants and default bit timing.
// Pure declarations; no latency or flow control involved.
package trena_pkg;

   typedef enum logic [3:0] {
      INICIAL  = 4'd0,
      START    = 4'd1,
      DADOS    = 4'd2,
      PARIDADE = 4'd3,
      STOP     = 4'd4,
      ENTREGA  = 4'd5
   } rx_estado_t;

   localparam int RX_DATA_BITS        = 7;
   localparam int RX_FRAME_BITS       = 10;
   localparam int RX_CLKS_PER_BIT_DEF = 5208;

endpackage

// File: rtl/contador_m.sv
// Modulo-M free-running counter; fim flags the last count (M-1), meio flags count M/2-1.
// Zero latency on flags; zera has priority over conta, no backpressure.
module contador_m #(
   parameter int M = 8
) (
   input  logic core_clk,
   input  logic arst_n,
   input  logic zera,
   input  logic conta,
   output logic fim,
   output logic meio
);

   localparam int N = $clog2(M);
   localparam logic [N-1:0] ULTIMO = N'(M - 1);
   localparam logic [N-1:0] METADE = N'(M / 2 - 1);

   logic [N-1:0] q;

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         q <= '0;
      end else if (zera) begin
         q <= '0;
      end else if (conta) begin
         q <= (q == ULTIMO) ? '0 : q + 1'b1;
      end
   end

   assign fim  = (q == ULTIMO);
   assign meio = (q == METADE);

endmodule

// File: rtl/rx_serial_7e1.sv
// 7E1 async serial receiver: pronto 2 + C/2 + 9C + 1 cycles after the start edge; sticky tem_dado, no backpressure.
// Parity is enforced only when RX_PARITY_CHECK_EN is defined; otherwise validity is stop bit only.
module rx_serial_7e1
   import trena_pkg::*;
#(
   parameter int CLKS_PER_BIT = RX_CLKS_PER_BIT_DEF
) (
   input  logic                    core_clk,
   input  logic                    arst_n,
   input  logic                    dado_serial,
   input  logic                    limpa,
   output logic [RX_DATA_BITS-1:0] dados_ascii,
   output logic                    tem_dado,
   output logic                    pronto,
   output logic                    erro_paridade,
   output logic                    erro_frame,
   output logic [3:0]              db_estado
);

   localparam int NB_W = $clog2(RX_DATA_BITS);
   localparam logic [NB_W-1:0] ULTIMO_BIT = NB_W'(RX_DATA_BITS - 1);

   rx_estado_t              estado;
   logic                    sync1;
   logic                    rx;
   logic [NB_W-1:0]         n_bits;
   logic [RX_DATA_BITS-1:0] shift;
   logic                    bit_stop;
   logic                    fim;
   logic                    meio;
   logic                    zera;
   logic                    conta;
   logic                    par_erro;
   logic                    quadro_ok;

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         sync1 <= 1'b1;
         rx    <= 1'b1;
      end else begin
         sync1 <= dado_serial;
         rx    <= sync1;
      end
   end

   // Bit-period timer restarts at the start edge and again at the start recheck,
   // so every later sample lands one full period after the previous one.
   assign zera  = (estado == INICIAL) || ((estado == START) && meio);
   assign conta = (estado != INICIAL);

   contador_m #(
      .M (CLKS_PER_BIT)
   ) u_tempo (
      .core_clk (core_clk),
      .arst_n   (arst_n),
      .zera     (zera),
      .conta    (conta),
      .fim      (fim),
      .meio     (meio)
   );

`ifdef RX_PARITY_CHECK_EN
   logic bit_par;

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         bit_par <= 1'b0;
      end else if ((estado == PARIDADE) && fim) begin
         bit_par <= rx;
      end
   end

   assign par_erro = ^{shift, bit_par};
`else
   assign par_erro = 1'b0;
`endif

   assign quadro_ok = bit_stop & ~par_erro;

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         estado        <= INICIAL;
         n_bits        <= '0;
         shift         <= '0;
         bit_stop      <= 1'b0;
         dados_ascii   <= '0;
         tem_dado      <= 1'b0;
         pronto        <= 1'b0;
         erro_paridade <= 1'b0;
         erro_frame    <= 1'b0;
      end else begin
         pronto <= 1'b0;
         if (limpa) begin
            tem_dado <= 1'b0;
         end
         case (estado)
            INICIAL: begin
               if (!rx) begin
                  estado <= START;
               end
            end
            START: begin
               if (meio) begin
                  estado <= rx ? INICIAL : DADOS;
                  n_bits <= '0;
               end
            end
            DADOS: begin
               if (fim) begin
                  shift <= {rx, shift[RX_DATA_BITS-1:1]};
                  if (n_bits == ULTIMO_BIT) begin
                     estado <= PARIDADE;
                  end else begin
                     n_bits <= n_bits + 1'b1;
                  end
               end
            end
            PARIDADE: begin
               if (fim) begin
                  estado <= STOP;
               end
            end
            STOP: begin
               if (fim) begin
                  bit_stop <= rx;
                  estado   <= ENTREGA;
               end
            end
            ENTREGA: begin
               // A valid delivery overrides a simultaneous limpa.
               pronto        <= 1'b1;
               erro_paridade <= par_erro;
               erro_frame    <= ~bit_stop;
               if (quadro_ok) begin
                  dados_ascii <= shift;
                  tem_dado    <= 1'b1;
               end
               estado <= INICIAL;
            end
            default: estado <= INICIAL;
         endcase
      end
   end

   assign db_estado = estado;

endmodule
